// File: rtl/vadd_lane_adder.sv
// -----------------------------------------------------------------------------
// vadd_lane_adder
//   Multi-lane integer adder stage for the vector-add datapath. Each accepted
//   beat is split into LANES = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH unsigned
//   lanes and every lane is transformed by the per-packet mode:
//     0 ADD    : x + K      (mod 2^W)
//     1 SUB    : x - K      (mod 2^W)
//     2 SATADD : min(x + K, 2^W - 1)
//     3 ACCUM  : acc + x, acc <= acc + x, acc cleared after tlast
//   The mode and K are captured on the first beat of a packet and held until
//   tlast. Results travel through C_PIPE_STAGES registers into a first-word-
//   fall-through FIFO of C_FIFO_DEPTH entries. Input backpressure is credit
//   exact: a beat is only accepted when a FIFO slot is already reserved.
//
// Build option:
//   VADD_LANE_KEEP_MASK_EN - when defined, a lane whose tkeep bytes are not
//   all set passes x through unmodified and does not update its accumulator.
//
// Ports:
//   s_axis_aclk    clock for both stream sides
//   s_axis_areset  asynchronous reset, active-high
//   ctrl_constant  per-packet operand K (W bits)
//   ctrl_mode      per-packet mode (2 bits)
//   s_axis_*       input AXI4-Stream (tvalid/tready/tdata/tkeep/tlast)
//   m_axis_*       output AXI4-Stream (tvalid/tready/tdata/tkeep/tlast)
// -----------------------------------------------------------------------------
module vadd_lane_adder #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_PIPE_STAGES      = 2,
  parameter int C_FIFO_DEPTH       = 32
) (
  input  logic                              s_axis_aclk,
  input  logic                              s_axis_areset,
  input  logic [C_ADDER_BIT_WIDTH-1:0]      ctrl_constant,
  input  logic [1:0]                        ctrl_mode,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                              s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                              m_axis_tlast
);

  localparam int W     = C_ADDER_BIT_WIDTH;
  localparam int DW    = C_AXIS_TDATA_WIDTH;
  localparam int KW    = DW / 8;
  localparam int LANES = DW / W;
  localparam int BPL   = W / 8;
  localparam int AW    = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam int UW    = AW + 1;
  localparam int EW    = DW + KW + 1;

  localparam logic [UW-1:0] DEPTH_U = UW'(C_FIFO_DEPTH);

  typedef enum logic [1:0] {
    MODE_ADD    = 2'd0,
    MODE_SUB    = 2'd1,
    MODE_SATADD = 2'd2,
    MODE_ACCUM  = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Handshake and packet tracking
  // ---------------------------------------------------------------------------
  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            pop;
  logic [W-1:0]    k_r;
  mode_t           mode_r;
  logic [W-1:0]    k_eff;
  mode_t           mode_eff;

  assign accept = s_axis_tvalid && s_axis_tready;
  assign pop    = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = s_axis_tlast ? ST_IDLE : ST_IN_PKT;
    end
  end

  // The first beat of a packet must already use the new operands, so in IDLE
  // the live control inputs bypass the (not yet loaded) holding registers.
  always_comb begin
    k_eff    = k_r;
    mode_eff = mode_r;
    if (state == ST_IDLE) begin
      k_eff    = ctrl_constant;
      mode_eff = mode_t'(ctrl_mode);
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      k_r    <= '0;
      mode_r <= MODE_ADD;
    end else if (accept && (state == ST_IDLE)) begin
      k_r    <= ctrl_constant;
      mode_r <= mode_t'(ctrl_mode);
    end
  end

  // ---------------------------------------------------------------------------
  // Lane arithmetic
  // ---------------------------------------------------------------------------
  logic [W-1:0]  acc      [LANES];
  logic [W-1:0]  acc_next [LANES];
  logic [DW-1:0] lane_res;
  logic [W-1:0]  lane_x;
  logic [W:0]    lane_sum;
  logic [W-1:0]  lane_r;
  logic          lane_on;

  always_comb begin
    lane_res = '0;
    lane_x   = '0;
    lane_sum = '0;
    lane_r   = '0;
    lane_on  = 1'b1;
    for (int unsigned i = 0; i < LANES; i++) begin
      acc_next[i] = acc[i];
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_x   = s_axis_tdata[i*W +: W];
      lane_sum = {1'b0, lane_x} + {1'b0, k_eff};
`ifdef VADD_LANE_KEEP_MASK_EN
      lane_on  = &s_axis_tkeep[i*BPL +: BPL];
`else
      lane_on  = 1'b1;
`endif
      unique case (mode_eff)
        MODE_ADD:    lane_r = lane_sum[W-1:0];
        MODE_SUB:    lane_r = lane_x - k_eff;
        MODE_SATADD: lane_r = lane_sum[W] ? '1 : lane_sum[W-1:0];
        MODE_ACCUM: begin
          lane_r = acc[i] + lane_x;
          if (lane_on) begin
            acc_next[i] = lane_r;
          end
        end
      endcase
      if (!lane_on) begin
        lane_r = lane_x;
      end
      lane_res[i*W +: W] = lane_r;
    end
    // End of packet always leaves the accumulators clean for the next one.
    if (s_axis_tlast) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        acc_next[i] = '0;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        acc[i] <= '0;
      end
    end else if (accept) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        acc[i] <= acc_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath pipeline. It never stalls: credits guarantee a FIFO slot for
  // every beat in flight, so only the valid bits need a reset.
  // ---------------------------------------------------------------------------
  logic [C_PIPE_STAGES-1:0] pipe_vld;
  logic [EW-1:0]            pipe_q [C_PIPE_STAGES];

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int unsigned s = 1; s < C_PIPE_STAGES; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    pipe_q[0] <= {s_axis_tlast, s_axis_tkeep, lane_res};
    for (int unsigned s = 1; s < C_PIPE_STAGES; s++) begin
      pipe_q[s] <= pipe_q[s-1];
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through output FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0]  mem [C_FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [UW-1:0]  fifo_cnt;
  logic           fifo_wr;
  logic [EW-1:0]  head;

  assign fifo_wr = pipe_vld[C_PIPE_STAGES-1];

  always_ff @(posedge s_axis_aclk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= pipe_q[C_PIPE_STAGES-1];
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({fifo_wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + UW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - UW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Output is gated to zero while empty so the memory never needs a reset.
  assign m_axis_tvalid = (fifo_cnt != '0);
  assign head          = m_axis_tvalid ? mem[rd_ptr] : '0;
  assign m_axis_tdata  = head[DW-1:0];
  assign m_axis_tkeep  = head[DW +: KW];
  assign m_axis_tlast  = head[EW-1];

  // ---------------------------------------------------------------------------
  // Credit counter: beats in the pipeline plus beats held in the FIFO.
  // tready is registered from the next credit value, which keeps it free of
  // any path from m_axis_tready and holds it low until the first clock after
  // reset release.
  // ---------------------------------------------------------------------------
  logic [UW-1:0] used;
  logic [UW-1:0] used_next;
  logic          tready_r;

  always_comb begin
    used_next = used;
    if (accept && !pop) begin
      used_next = used + UW'(1);
    end else if (!accept && pop) begin
      used_next = used - UW'(1);
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      used     <= '0;
      tready_r <= 1'b0;
    end else begin
      used     <= used_next;
      tready_r <= (used_next < DEPTH_U);
    end
  end

  assign s_axis_tready = tready_r;

endmodule

// File: tb/tb_vadd_lane_adder.sv
module tb_vadd_lane_adder;

  localparam int DW    = 128;
  localparam int W     = 32;
  localparam int P     = 2;
  localparam int DEPTH = 8;
  localparam int LANES = DW / W;
  localparam int KW    = DW / 8;
  localparam longint unsigned MOD = 64'd1 << W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  ctrl_constant = '0;
  logic [1:0]    ctrl_mode = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;

  always #5 clk = ~clk;

  vadd_lane_adder #(
    .C_AXIS_TDATA_WIDTH (DW),
    .C_ADDER_BIT_WIDTH  (W),
    .C_PIPE_STAGES      (P),
    .C_FIFO_DEPTH       (DEPTH)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .ctrl_constant (ctrl_constant),
    .ctrl_mode     (ctrl_mode),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] k;
    logic [W-1:0] x;
    logic [W-1:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] pop_log[$];
  int            cyc = 0;
  int            last_acc_cyc = 0;
  int            tv_cyc = 0;
  logic          tv_seen = 1'b0;
  logic          acc_flag = 1'b0;
  int            acc_count = 0;

  // Reference model: packet-level view of the rules
  logic             model_open = 1'b0;
  logic [W-1:0]     model_k = '0;
  logic [1:0]       model_mode = '0;
  longint unsigned  model_acc [LANES];

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic void model_reset();
    model_open = 1'b0;
    model_k    = '0;
    model_mode = '0;
    for (int i = 0; i < LANES; i++) model_acc[i] = 0;
    exp_q.delete();
  endfunction

  function automatic void model_accept();
    beat_t e;
    longint unsigned xs, ks, r;
    logic masked;
    if (!model_open) begin
      model_k    = ctrl_constant;
      model_mode = ctrl_mode;
    end
    ks  = model_k;
    e.d = '0;
    e.k = s_tkeep;
    e.l = s_tlast;
    for (int i = 0; i < LANES; i++) begin
      xs = s_tdata[i*W +: W];
      masked = 1'b0;
`ifdef VADD_LANE_KEEP_MASK_EN
      masked = (s_tkeep[i*(W/8) +: (W/8)] != {(W/8){1'b1}});
`endif
      if (masked) begin
        r = xs;
      end else begin
        case (model_mode)
          2'd0: r = (xs + ks) % MOD;
          2'd1: r = (xs + MOD - ks) % MOD;
          2'd2: r = (xs + ks > MOD - 1) ? MOD - 1 : xs + ks;
          default: begin
            r = (model_acc[i] + xs) % MOD;
            model_acc[i] = r;
          end
        endcase
      end
      e.d[i*W +: W] = W'(r);
    end
    if (s_tlast) begin
      for (int i = 0; i < LANES; i++) model_acc[i] = 0;
    end
    model_open = !s_tlast;
    exp_q.push_back(e);
  endfunction

  // One clock: observe handshakes at the falling edge, then return just after
  // the rising edge so the caller can drive the next cycle's inputs.
  task automatic step();
    beat_t e;
    @(negedge clk);
    acc_flag = 1'b0;
    if (!rst) begin
      acc_flag = s_tvalid && s_tready;
      if (m_tvalid && !tv_seen) begin
        tv_seen = 1'b1;
        tv_cyc  = cyc;
      end
      if (m_tvalid && m_tready) begin
        pop_log.push_back(m_tdata);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.d);
          chk("out_keep", DW'(m_tkeep), DW'(e.k));
          chk("out_last", DW'(m_tlast), DW'(e.l));
        end
      end
      if (acc_flag) begin
        model_accept();
        acc_count++;
        last_acc_cyc = cyc;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    do begin
      step();
      n++;
    end while (!acc_flag && n < 200);
    if (!acc_flag) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk("drain_left", DW'(exp_q.size()), '0);
    chk("drain_empty", DW'(m_tvalid), '0);
  endtask

  function automatic logic [DW-1:0] rep(input logic [W-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  vec_t vt [8];

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] want;
    int a0;

    vt[0] = '{2'd0, 32'd5,        32'd0,        32'd5};
    vt[1] = '{2'd0, 32'd1,        32'hFFFFFFFF, 32'd0};
    vt[2] = '{2'd1, 32'd1,        32'd0,        32'hFFFFFFFF};
    vt[3] = '{2'd1, 32'd3,        32'd10,       32'd7};
    vt[4] = '{2'd2, 32'h10,       32'hFFFFFFF8, 32'hFFFFFFFF};
    vt[5] = '{2'd2, 32'd7,        32'hFFFFFFF8, 32'hFFFFFFFF};
    vt[6] = '{2'd2, 32'd1,        32'hFFFFFFF0, 32'hFFFFFFF1};
    vt[7] = '{2'd3, 32'd99,       32'd7,        32'd7};

    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", DW'(s_tready), '0);
    chk("rst_m_tvalid", DW'(m_tvalid), '0);
    chk("rst_m_tdata",  m_tdata, '0);
    chk("rst_m_tkeep",  DW'(m_tkeep), '0);
    chk("rst_m_tlast",  DW'(m_tlast), '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("tready_before_edge", DW'(s_tready), '0);
    @(posedge clk);
    #1;
    chk("tready_after_release", DW'(s_tready), DW'(1));

    // ADD K=5, 4 beats of lane values 0..15, latency and throughput
    m_tready = 1'b1;
    ctrl_mode = 2'd0;
    ctrl_constant = 32'd5;
    pop_log.delete();
    tv_seen = 1'b0;
    a0 = 0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < LANES; i++) d[i*W +: W] = W'(4 * b + i);
      send_beat(d, '1, (b == 3));
      if (b == 0) a0 = last_acc_cyc;
    end
    drain();
    chk("add_latency", DW'(tv_cyc - a0), DW'(P + 1));
    chk("add_throughput", DW'(last_acc_cyc - a0), DW'(3));
    chk("add_count", DW'(pop_log.size()), DW'(4));
    for (int b = 0; b < 4 && b < pop_log.size(); b++) begin
      for (int i = 0; i < LANES; i++) want[i*W +: W] = W'(4 * b + i + 5);
      chk("add_beat", pop_log[b], want);
    end

    // Table of single-beat packets
    for (int t = 0; t < 8; t++) begin
      ctrl_mode = vt[t].mode;
      ctrl_constant = vt[t].k;
      pop_log.delete();
      send_beat(rep(vt[t].x), '1, 1'b1);
      drain();
      if (pop_log.size() == 1) chk("table_vec", pop_log[0], rep(vt[t].exp));
      else chk("table_count", DW'(pop_log.size()), DW'(1));
    end

    // ACCUM 2,3,4 then a new packet of 7
    ctrl_mode = 2'd3;
    ctrl_constant = 32'd0;
    pop_log.delete();
    send_beat(rep(32'd2), '1, 1'b0);
    send_beat(rep(32'd3), '1, 1'b0);
    send_beat(rep(32'd4), '1, 1'b1);
    send_beat(rep(32'd7), '1, 1'b1);
    drain();
    chk("accum_count", DW'(pop_log.size()), DW'(4));
    if (pop_log.size() == 4) begin
      chk("accum_b0", pop_log[0], rep(32'd2));
      chk("accum_b1", pop_log[1], rep(32'd5));
      chk("accum_b2", pop_log[2], rep(32'd9));
      chk("accum_new_pkt", pop_log[3], rep(32'd7));
    end

    // Mid-packet control change is ignored until the next packet
    ctrl_mode = 2'd0;
    ctrl_constant = 32'd5;
    pop_log.delete();
    send_beat(rep(32'd10), '1, 1'b0);
    ctrl_constant = 32'd9;
    ctrl_mode = 2'd1;
    send_beat(rep(32'd10), '1, 1'b0);
    send_beat(rep(32'd10), '1, 1'b1);
    ctrl_mode = 2'd0;
    send_beat(rep(32'd10), '1, 1'b1);
    drain();
    chk("hold_count", DW'(pop_log.size()), DW'(4));
    if (pop_log.size() == 4) begin
      chk("hold_b0", pop_log[0], rep(32'd15));
      chk("hold_b1", pop_log[1], rep(32'd15));
      chk("hold_b2", pop_log[2], rep(32'd15));
      chk("hold_next_pkt", pop_log[3], rep(32'd19));
    end

    // Full: exactly DEPTH beats accepted with the output stalled
    m_tready = 1'b0;
    acc_count = 0;
    ctrl_mode = 2'($urandom_range(0, 3));
    ctrl_constant = $urandom;
    s_tdata = rand_data();
    s_tkeep = KW'($urandom);
    s_tlast = 1'($urandom_range(0, 1));
    s_tvalid = 1'b1;
    for (int n = 0; n < DEPTH + 8; n++) begin
      step();
      if (acc_flag) begin
        s_tdata = rand_data();
        s_tkeep = KW'($urandom);
        s_tlast = 1'($urandom_range(0, 1));
        ctrl_mode = 2'($urandom_range(0, 3));
        ctrl_constant = $urandom;
      end
    end
    s_tvalid = 1'b0;
    chk("full_accepts", DW'(acc_count), DW'(DEPTH));
    chk("full_tready", DW'(s_tready), '0);
    chk("full_tvalid", DW'(m_tvalid), DW'(1));
    m_tready = 1'b1;
    step();
    chk("tready_after_pop", DW'(s_tready), DW'(1));
    drain();

    // Randomized traffic against the model
    s_tvalid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!s_tvalid || acc_flag) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        s_tdata  = rand_data();
        s_tkeep  = KW'($urandom);
        s_tlast  = ($urandom_range(0, 3) == 0);
      end
      ctrl_mode = 2'($urandom_range(0, 3));
      ctrl_constant = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      m_tready = ($urandom_range(0, 3) != 0);
      step();
    end
    s_tvalid = 1'b0;
    drain();

    // Reset mid-packet with the FIFO half full
    m_tready = 1'b0;
    ctrl_mode = 2'd0;
    ctrl_constant = 32'd3;
    for (int b = 0; b < DEPTH / 2; b++) send_beat(rep(W'(b)), '1, 1'b0);
    repeat (P + 1) step();
    chk("pre_reset_tvalid", DW'(m_tvalid), DW'(1));
    rst = 1'b1;
    #1;
    chk("midrst_m_tvalid", DW'(m_tvalid), '0);
    chk("midrst_s_tready", DW'(s_tready), '0);
    chk("midrst_m_tdata", m_tdata, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    m_tready = 1'b1;
    ctrl_mode = 2'd0;
    ctrl_constant = 32'd1;
    pop_log.delete();
    send_beat(rep(32'd0), '1, 1'b1);
    drain();
    chk("post_rst_count", DW'(pop_log.size()), DW'(1));
    if (pop_log.size() == 1) chk("post_rst_value", pop_log[0], rep(32'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vadd_lane_adder.md
# vadd_lane_adder

Parametrised multi-lane integer adder stage for the vector-add kernel datapath. It sits between the read-master AXI4-Stream and the write-master AXI4-Stream and applies one of four per-packet arithmetic modes to every lane of each beat. Data passes through a configurable-depth pipeline into an internal first-word-fall-through FIFO. Input backpressure is credit-exact: a beat is never accepted unless FIFO space is already reserved for it.

## Interface
- C_AXIS_TDATA_WIDTH, 512: stream data width; must be a multiple of C_ADDER_BIT_WIDTH.
- C_ADDER_BIT_WIDTH, 32: lane width W; LANES = C_AXIS_TDATA_WIDTH / W; W must be a multiple of 8.
- C_PIPE_STAGES, 2: datapath register stages, range 1..8.
- C_FIFO_DEPTH, 32: output FIFO entries; power of two, at least C_PIPE_STAGES + 2.
- s_axis_aclk  in  1  single clock for both stream sides.
- s_axis_areset  in  1  asynchronous reset, active-high.
- ctrl_constant  in  W  per-packet operand K.
- ctrl_mode  in  2  per-packet mode: 0 ADD, 1 SUB, 2 SATADD, 3 ACCUM.
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  input handshake.
- s_axis_tdata / s_axis_tkeep / s_axis_tlast  in  C_AXIS_TDATA_WIDTH / C_AXIS_TDATA_WIDTH/8 / 1  input payload.
- m_axis_tvalid / m_axis_tready  out / in  1 / 1  output handshake.
- m_axis_tdata / m_axis_tkeep / m_axis_tlast  out  same widths  output payload.

## Operation
- A beat is accepted when s_axis_tvalid && s_axis_tready.
- Packet state machine, two states:
  - IDLE: no packet in progress.
  - IN_PKT: packet in progress.
  - IDLE→IN_PKT on acceptance of a beat with tlast=0.
  - IN_PKT→IDLE on acceptance of a beat with tlast=1.
  - A single-beat packet stays in IDLE.
- ctrl_constant and ctrl_mode are latched into K_r / MODE_r on every beat accepted in IDLE and held for the rest of the packet. Mid-packet changes to either input are ignored.
- Per lane i, with operand x = tdata[i*W +: W] (unsigned):
  - ADD: x + K_r mod 2^W.
  - SUB: x − K_r mod 2^W.
  - SATADD: min(x + K_r, 2^W − 1).
  - ACCUM: output acc_i + x mod 2^W, then acc_i ← acc_i + x. All acc_i clear to 0 after the tlast beat and at reset. The first beat of a packet therefore outputs x.
- tkeep and tlast travel alongside the data unchanged.
- Credit counter: used = fifo_count + inflight, where inflight counts beats inside the pipeline.
  - s_axis_tready = (used < C_FIFO_DEPTH). It is driven from registers only; there is no combinational path from m_axis_tready.
  - used increments on accept, decrements on output pop, and is unchanged when both happen in the same cycle.
- The FIFO is first-word-fall-through. The output holds tdata, tkeep and tlast stable while m_axis_tvalid && !m_axis_tready.

## Timing
- Reset (asynchronous assert, synchronous-release domain):
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0.
  - State IDLE, used=0, acc=0, K_r=0, MODE_r=0.
- s_axis_tready rises on the first s_axis_aclk edge after s_axis_areset deasserts.
- Latency from accept to m_axis_tvalid is C_PIPE_STAGES + 1 cycles, given an empty FIFO.
- Sustained throughput is 1 beat/cycle while m_axis_tready=1.
- Full condition: with C_FIFO_DEPTH beats stored or in flight, tready=0. tready returns to 1 in the cycle after the first pop.
- Simultaneous accept and pop when used = C_FIFO_DEPTH cannot occur, because tready=0 in that state. At used = C_FIFO_DEPTH−1, accept and pop together leave used unchanged and tready stays 1.
- Empty condition: m_axis_tvalid=0. A write into an empty FIFO appears on the output the next cycle.
- FIFO pointers wrap modulo C_FIFO_DEPTH with no lost or duplicated beats.
- A reset asserted mid-packet discards all pipeline and FIFO contents within the same cycle. The next accepted beat starts a new packet.

## Configuration
- VADD_LANE_KEEP_MASK_EN defined: any lane whose W/8 tkeep bits are not all 1 passes x through unmodified. In ACCUM mode such a lane does not update acc_i.
- VADD_LANE_KEEP_MASK_EN undefined: tkeep is ignored for arithmetic and every lane is computed.

## Test plan
- ADD, W=32, K=5: 4-beat packet with lane values 0..15 and m_axis_tready=1 → outputs 5..20. First output appears C_PIPE_STAGES+1 cycles after the first accept; tlast is set on beat 4 only.
- SUB with K=1 on lane value 0, then SATADD with K=0x10 on 0xFFFFFFF8 → outputs 0xFFFFFFFF (wrap) and 0xFFFFFFFF (clamp).
- ACCUM with a 3-beat packet where all lanes are 2, 3, 4, followed by a second 1-beat packet of 7 → outputs 2, 5, 9, then 7 (accumulator cleared).
- Hold m_axis_tready=0 while driving tvalid continuously → exactly C_FIFO_DEPTH beats accepted, then tready=0. Release m_axis_tready → all beats drain in order, and tready returns 1 cycle after the first pop.
- Change ctrl_constant from 5 to 9 at beat 2 of a 3-beat ADD packet → all 3 beats use 5. The next packet uses 9.
- Assert s_axis_areset mid-packet with the FIFO half full → m_axis_tvalid=0 and tready=0 immediately. After release, a fresh 1-beat ADD K=1 on value 0 outputs 1.
